// File: rtl/ifid_buffer_if.sv
// IF/ID handshake bundle: fetch-side push channel, decode-side pop channel and branch flush.
// The master modport belongs to the fetch/decode environment; the slave modport belongs to the buffer.
interface ifid_buffer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             if_valid;
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_pc_plus2;
    logic             if_ready;
    logic             flush;
    logic             id_valid;
    logic [WIDTH-1:0] id_instr;
    logic [WIDTH-1:0] id_pc_plus2;
    logic             id_ready;

    modport master (
        output if_valid, if_instr, if_pc_plus2, flush, id_ready,
        input  if_ready, id_valid, id_instr, id_pc_plus2
    );

    modport slave (
        input  if_valid, if_instr, if_pc_plus2, flush, id_ready,
        output if_ready, id_valid, id_instr, id_pc_plus2
    );
endinterface

// File: rtl/ifid_buffer.sv
// Two-entry IF/ID skid buffer with branch flush and sticky halt detection.
// Optional IFID_PERF_EN adds saturating stall_cycles / flush_count counters.
module ifid_buffer #(
    parameter int unsigned WIDTH       = 16,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    ifid_buffer_if.slave       bus,
`ifdef IFID_PERF_EN
    output logic [15:0]        stall_cycles,
    output logic [15:0]        flush_count,
`endif
    output logic               halted
);
    logic [1:0]       count_q, count_d;
    logic             head_q;
    logic             tail_q;
    logic             halted_q;
    logic [WIDTH-1:0] instr_q [2];
    logic [WIDTH-1:0] pc_q    [2];

    logic             push;
    logic             pop;
    logic             ready_int;
    logic             valid_int;

    // Fetch readiness depends only on registered state, so decode stalls never reach fetch.
    always_comb begin
        ready_int = (count_q != 2'd2) & ~halted_q;
        valid_int = (count_q != 2'd0);
        push      = bus.if_valid & ready_int;
        pop       = valid_int & bus.id_ready;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (bus.flush) begin
            // A HLT fetched on the wrong path is discarded along with the sticky flag.
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                instr_q[tail_q] <= bus.if_instr;
                pc_q[tail_q]    <= bus.if_pc_plus2;
                tail_q          <= ~tail_q;
                if (bus.if_instr[WIDTH-1:WIDTH-4] == HALT_OPCODE) begin
                    halted_q <= 1'b1;
                end
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    always_comb begin
        bus.if_ready    = ready_int;
        bus.id_valid    = valid_int;
        bus.id_instr    = valid_int ? instr_q[head_q] : '0;
        bus.id_pc_plus2 = valid_int ? pc_q[head_q] : '0;
        halted          = halted_q;
    end

`ifdef IFID_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else begin
            if (valid_int && !bus.id_ready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (bus.flush && flush_q != 16'hFFFF) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    always_comb begin
        stall_cycles = stall_q;
        flush_count  = flush_q;
    end
`endif
endmodule

// File: tb/tb_ifid_buffer.sv
// Self-checking bench for ifid_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifid_buffer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic halted;
`ifdef IFID_PERF_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    ifid_buffer_if #(.WIDTH(W)) bus ();

    ifid_buffer #(
        .WIDTH      (W),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
`ifdef IFID_PERF_EN
        .stall_cycles(stall_cycles),
        .flush_count (flush_count),
`endif
        .halted      (halted)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    ent_t mq[$];
    bit   m_halted = 1'b0;
    int   m_stall  = 0;
    int   m_flush  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries plus a sticky halt bit.
    always @(posedge clk) begin
        int   sz;
        bit   push;
        bit   pop;
        ent_t e;
        sz = mq.size();
        if (rst === 1'b1) begin
            mq.delete();
            m_halted = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            if (sz != 0 && !bus.id_ready && m_stall < 65535) m_stall++;
            if (bus.flush && m_flush < 65535) m_flush++;
            if (bus.flush) begin
                mq.delete();
                m_halted = 1'b0;
            end else begin
                push = bus.if_valid && sz != 2 && !m_halted;
                pop  = sz != 0 && bus.id_ready;
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.instr = bus.if_instr;
                    e.pc    = bus.if_pc_plus2;
                    mq.push_back(e);
                    if (bus.if_instr[15:12] == 4'hF) m_halted = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_if_ready", bus.if_ready, (mq.size() != 2) && !m_halted);
            check("cmp_id_valid", bus.id_valid, mq.size() != 0);
            check("cmp_id_instr", bus.id_instr, (mq.size() != 0) ? mq[0].instr : 16'h0000);
            check("cmp_id_pc", bus.id_pc_plus2, (mq.size() != 0) ? mq[0].pc : 16'h0000);
            check("cmp_halted", halted, m_halted);
`ifdef IFID_PERF_EN
            check("cmp_stall_cycles", stall_cycles, m_stall);
            check("cmp_flush_count", flush_count, m_flush);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [15:0] instr, input logic [15:0] pc);
        bus.if_valid    = v;
        bus.if_instr    = instr;
        bus.if_pc_plus2 = pc;
    endtask

    initial begin
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        step();
        step();
        chk_en = 1'b1;
        check("rst_id_valid", bus.id_valid, 0);
        check("rst_if_ready", bus.if_ready, 1);
        check("rst_halted", halted, 0);
        check("rst_id_instr", bus.id_instr, 16'h0000);
        rst = 1'b0;

        // Streaming
        bus.id_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h0002);
        step();
        check("stream_0", bus.id_instr, 16'h1234);
        check("stream_0_pc", bus.id_pc_plus2, 16'h0002);
        check("stream_0_rdy", bus.if_ready, 1);
        drive(1'b1, 16'h2345, 16'h0004);
        step();
        check("stream_1", bus.id_instr, 16'h2345);
        check("stream_1_rdy", bus.if_ready, 1);
        drive(1'b1, 16'h3456, 16'h0006);
        step();
        check("stream_2", bus.id_instr, 16'h3456);
        check("stream_2_pc", bus.id_pc_plus2, 16'h0006);
        drive(1'b0, 16'h0000, 16'h0000);
        step();
        check("stream_empty", bus.id_valid, 0);

        // Stall fill
        bus.id_ready = 1'b0;
        drive(1'b1, 16'hA001, 16'h0010);
        step();
        check("stall_head0", bus.id_instr, 16'hA001);
        check("stall_rdy0", bus.if_ready, 1);
        drive(1'b1, 16'hA002, 16'h0012);
        step();
        check("stall_rdy1", bus.if_ready, 0);
        check("stall_head1", bus.id_instr, 16'hA001);
        check("model_full", mq.size(), 2);
        drive(1'b1, 16'hA003, 16'h0014);
        step();
        check("stall_rdy2", bus.if_ready, 0);
        check("stall_head2", bus.id_instr, 16'hA001);
        drive(1'b0, 16'h0000, 16'h0000);
        bus.id_ready = 1'b1;
        step();
        check("drain_a002", bus.id_instr, 16'hA002);
        check("drain_a002_pc", bus.id_pc_plus2, 16'h0012);
        step();
        check("drain_empty", bus.id_valid, 0);
        check("drain_rdy", bus.if_ready, 1);

        // Flush with simultaneous push
        bus.id_ready = 1'b0;
        drive(1'b1, 16'hC001, 16'h0020);
        step();
        drive(1'b1, 16'hC002, 16'h0022);
        step();
        check("flush_pre_full", bus.if_ready, 0);
        bus.flush = 1'b1;
        drive(1'b1, 16'hB000, 16'h0030);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        check("flush_valid", bus.id_valid, 0);
        check("flush_instr", bus.id_instr, 16'h0000);
        bus.id_ready = 1'b1;
        step();
        check("flush_no_b000", bus.id_valid, 0);

        // Halt
        drive(1'b1, 16'h1111, 16'h0040);
        step();
        check("halt_pre", bus.id_instr, 16'h1111);
        check("halt_pre_flag", halted, 0);
        drive(1'b1, 16'hF000, 16'h0042);
        step();
        check("halt_flag", halted, 1);
        check("halt_rdy", bus.if_ready, 0);
        check("halt_instr", bus.id_instr, 16'hF000);
        check("model_halted", m_halted, 1);
        drive(1'b1, 16'h2222, 16'h0044);
        step();
        check("halt_nothing_more", bus.id_valid, 0);
        step();
        check("halt_still_empty", bus.id_valid, 0);
        check("halt_still_blocked", bus.if_ready, 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        check("halt_flush_flag", halted, 0);
        check("halt_flush_rdy", bus.if_ready, 1);

        // Reset mid-operation
        bus.id_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h0050);
        step();
        drive(1'b1, 16'hF000, 16'h0052);
        step();
        check("mid_halted", halted, 1);
        check("mid_full", bus.if_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        check("mid_rst_valid", bus.id_valid, 0);
        check("mid_rst_rdy", bus.if_ready, 1);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_instr", bus.id_instr, 16'h0000);
        check("mid_rst_pc", bus.id_pc_plus2, 16'h0000);

`ifdef IFID_PERF_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.id_ready = 1'b0;
        drive(1'b1, 16'hE001, 16'h0060);
        step();
        drive(1'b0, 16'h0000, 16'h0000);
        repeat (5) step();
        bus.id_ready = 1'b1;
        bus.flush    = 1'b1;
        step();
        step();
        bus.flush = 1'b0;
        check("perf_stall", stall_cycles, 16'd5);
        check("perf_flush", flush_count, 16'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.flush    = ($urandom_range(0, 15) == 0);
            bus.id_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            step();
        end
        rst       = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
